// File: rtl/dmux_pkg.sv
// Shared constants and types for the buffered 1-to-4 datapath steering unit.
package dmux_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned NUM_SLOTS = 4;

  localparam int unsigned SLOT0 = 0;
  localparam int unsigned SLOT1 = 1;
  localparam int unsigned SLOT2 = 2;
  localparam int unsigned SLOT3 = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/dmux_slot_32.sv
// One-entry holding register with valid/ready drain; a load always wins over a drain.
module dmux_slot_32 #(
  parameter int unsigned DATA_W = dmux_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);
  import dmux_pkg::*;

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Load replaces any held word (even one being drained); drain only clears valid.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
          data_d  = din;
        end
      end
      FULL: begin
        if (load) begin
          data_d = din;
        end else if (ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign valid = (state_q == FULL);
  assign dout  = data_q;

endmodule

// File: rtl/dmux1t4_32_buf.sv
// Buffered 1-to-4 steering unit: one producer fanned out to four independently
// stalling sinks, each behind its own one-entry holding register.
module dmux1t4_32_buf #(
  parameter int unsigned DATA_W = dmux_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [dmux_pkg::SEL_W-1:0]     sel,
  input  logic [DATA_W-1:0]              data_in,
  output logic [dmux_pkg::NUM_SLOTS-1:0] out_valid,
  input  logic [dmux_pkg::NUM_SLOTS-1:0] out_ready,
  output logic [DATA_W-1:0]              data_out_0,
  output logic [DATA_W-1:0]              data_out_1,
  output logic [DATA_W-1:0]              data_out_2,
  output logic [DATA_W-1:0]              data_out_3,
  output logic                           busy
);
  import dmux_pkg::*;

  logic [NUM_SLOTS-1:0] load;
  logic [DATA_W-1:0]    slot_dout [NUM_SLOTS];

  // Only the addressed slot gates acceptance, so a stalled sink blocks only itself.
  assign in_ready = ~out_valid[sel] | out_ready[sel];

  always_comb begin
    load = '0;
    if (in_valid && in_ready) begin
      load[sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    dmux_slot_32 #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (data_in),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .dout  (slot_dout[k])
    );
  end

  assign data_out_0 = slot_dout[SLOT0];
  assign data_out_1 = slot_dout[SLOT1];
  assign data_out_2 = slot_dout[SLOT2];
  assign data_out_3 = slot_dout[SLOT3];
  assign busy       = |out_valid;

endmodule

// File: tb/tb_dmux1t4_32_buf.sv
// Self-checking bench for dmux1t4_32_buf: vector table, directed corner cases,
// and randomized traffic against a slot-array reference model.
module tb_dmux1t4_32_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [31:0] data_in;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each slot is simply "holds a word or not" plus the word.
  logic [3:0]  mv;
  logic [31:0] md [4];

  always #5 clk = ~clk;

  dmux1t4_32_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .data_out_3 (data_out_3),
    .busy       (busy)
  );

  typedef struct {
    logic        in_valid;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [3:0]  ready;
    logic        exp_in_ready;
    logic [3:0]  exp_valid;
  } vec_t;

  function automatic logic [31:0] dout(input int k);
    case (k)
      0: return data_out_0;
      1: return data_out_1;
      2: return data_out_2;
      default: return data_out_3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return !mv[sel] || out_ready[sel];
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic tick();
    logic [3:0]  nv;
    logic [31:0] nd [4];
    logic        acc;
    acc = in_valid && model_ready();
    for (int k = 0; k < 4; k++) begin
      nv[k] = mv[k];
      nd[k] = md[k];
      if (acc && sel == 2'(k)) begin
        nv[k] = 1'b1;
        nd[k] = data_in;
      end else if (mv[k] && out_ready[k]) begin
        nv[k] = 1'b0;
      end
      if (!rst_n) begin
        nv[k] = 1'b0;
        nd[k] = '0;
      end
    end
    @(posedge clk);
    #1;
    mv = nv;
    for (int k = 0; k < 4; k++) md[k] = nd[k];
  endtask

  task automatic check_model(input string tag);
    logic ok;
    ok = (out_valid === mv) && (busy === |mv) && (in_ready === model_ready());
    for (int k = 0; k < 4; k++) ok = ok && (dout(k) === md[k]);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: valid %b/%b busy %b ready %b/%b d %h %h %h %h exp %h %h %h %h",
               tag, out_valid, mv, busy, in_ready, model_ready(),
               data_out_0, data_out_1, data_out_2, data_out_3, md[0], md[1], md[2], md[3]);
    end
  endtask

  vec_t vecs [8];

  initial begin
    logic pending;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd2;
    data_in   = 32'hDEADBEEF;
    out_ready = 4'b0000;
    mv        = '0;
    for (int k = 0; k < 4; k++) md[k] = '0;

    // Reset held two cycles with a word offered
    tick();
    tick();
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 4; k++) check($sformatf("reset_data%0d", k), dout(k), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);

    rst_n = 1'b1;
    tick();
    check("post_reset_valid", 32'(out_valid), 32'h4);
    check("post_reset_data2", data_out_2, 32'hDEADBEEF);
    in_valid  = 1'b0;
    out_ready = 4'b0100;
    tick();
    check("drain2_valid", 32'(out_valid), 32'h0);

    // Steer table: fill all four, backpressure, drain+load, drains
    vecs[0] = '{1'b1, 2'd0, 32'h11111111, 4'b0000, 1'b1, 4'b0001};
    vecs[1] = '{1'b1, 2'd1, 32'h22222222, 4'b0000, 1'b1, 4'b0011};
    vecs[2] = '{1'b1, 2'd2, 32'h33333333, 4'b0000, 1'b1, 4'b0111};
    vecs[3] = '{1'b1, 2'd3, 32'h44444444, 4'b0000, 1'b1, 4'b1111};
    vecs[4] = '{1'b1, 2'd1, 32'h55555555, 4'b0000, 1'b0, 4'b1111};
    vecs[5] = '{1'b1, 2'd1, 32'h55555555, 4'b0010, 1'b1, 4'b1111};
    vecs[6] = '{1'b0, 2'd0, 32'h0,        4'b0001, 1'b1, 4'b1110};
    vecs[7] = '{1'b0, 2'd0, 32'h0,        4'b1110, 1'b1, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      in_valid  = vecs[i].in_valid;
      sel       = vecs[i].sel;
      data_in   = vecs[i].din;
      out_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (i == 3) begin
        check("steer_d0", data_out_0, 32'h11111111);
        check("steer_d1", data_out_1, 32'h22222222);
        check("steer_d2", data_out_2, 32'h33333333);
        check("steer_d3", data_out_3, 32'h44444444);
        check("steer_busy", 32'(busy), 32'h1);
      end
      if (i == 5) check("drain_load_d1", data_out_1, 32'h55555555);
      check_model($sformatf("vec%0d_model", i));
    end

    // Backpressure on slot 1 while slot 3 stays free
    in_valid = 1'b1; sel = 2'd1; data_in = 32'hAAAA0001; out_ready = 4'b0000;
    tick();
    data_in = 32'hBBBB0002;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("bp_hold_d1", data_out_1, 32'hAAAA0001);
    end
    sel = 2'd3;
    #1;
    check("bp_switch_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_switch_d3", data_out_3, 32'hBBBB0002);
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
    check_model("bp_cleanup");

    // Streaming through slot 0
    sel = 2'd0; out_ready = 4'b0001; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 32'(i);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("stream_data", data_out_0, 32'(i));
      check("stream_valid0", 32'(out_valid[0]), 32'h1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(out_valid), 32'h0);

    // Same-cycle drain+load on slot 2 with drain of slot 0
    out_ready = 4'b0000; in_valid = 1'b1;
    sel = 2'd2; data_in = 32'hA0A0A0A0; tick();
    sel = 2'd0; data_in = 32'h0C0C0C0C; tick();
    sel = 2'd2; data_in = 32'hB0B0B0B0; out_ready = 4'b0101;
    tick();
    check("simul_d2", data_out_2, 32'hB0B0B0B0);
    check("simul_valid2", 32'(out_valid[2]), 32'h1);
    check("simul_valid0", 32'(out_valid[0]), 32'h0);

    // Reset in the middle of traffic
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); data_in = 32'hF0000000 | 32'(k); tick();
    end
    check("full_before_reset", 32'(out_valid), 32'hF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("midreset_valid", 32'(out_valid), 32'h0);
    check("midreset_in_ready", 32'(in_ready), 32'h1);
    check_model("midreset_model");

    // Randomized traffic; sel/data held while an offer is pending
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        sel      = 2'($urandom_range(0, 3));
        data_in  = $urandom;
      end
      out_ready = 4'($urandom);
      rst_n     = 1'($urandom_range(0, 99) != 0);
      #1;
      check_model("rand_pre");
      pending = in_valid && !model_ready() && rst_n;
      tick();
      check_model("rand_post");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmux1t4_32_buf.md
# dmux1t4_32_buf

Buffered 1-to-4 steering unit for 32-bit datapath traffic: one upstream source, four downstream sinks, selection by a 2-bit code. It is the fan-out counterpart of the 4:1 datapath select and distributes one producer's words (e.g. the core's store/IO-write path) to four consumers. Each output owns a one-entry holding register with a valid/ready handshake, so a stalled consumer blocks only itself.

## Interface
- `DATA_W`, default 32: word width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: unit accepts the word this cycle.
- `sel` input 2: destination slot, 0..3, sampled with `data_in`.
- `data_in` input DATA_W: upstream word.
- `out_valid` output 4: bit k set means slot k holds a word.
- `out_ready` input 4: bit k set means sink k takes slot k this cycle.
- `data_out_0`..`data_out_3` output DATA_W each: slot contents.
- `busy` output 1: OR of `out_valid`.

## Operation
- Accept: `in_ready = ~out_valid[sel] | out_ready[sel]`; transfer when `in_valid & in_ready`. `sel` and `data_in` must be stable while `in_valid` is high and the word is not yet accepted.
- Slot k next state (evaluate in order):
  - load: accept with `sel==k`, so `data_out_k <= data_in` and `out_valid[k] <= 1`;
  - drain: else if `out_valid[k] & out_ready[k]`, then `out_valid[k] <= 0` and data is held;
  - otherwise hold.
- Simultaneous drain and load on the same slot: the new word replaces the old and valid stays 1, giving full throughput of one word per cycle per slot.
- Draining slot j while loading slot k≠j: both happen independently.
- `out_ready[k]` with `out_valid[k]=0` has no effect.
- No reordering is possible per slot. Words to different slots have no ordering guarantee.
- `in_ready` is combinational from `sel`, `out_valid`, and `out_ready`. There is no combinational path from `data_in` to any output.

## Timing
- Reset (`rst_n=0` at a clock edge): `out_valid=0`, `busy=0`, all `data_out_k=0`. `in_ready` then evaluates to 1. Reset overrides any load or drain in the same cycle, and words in flight are discarded.
- Latency: a word accepted at edge N appears on `data_out_sel` with `out_valid` set after edge N.
- Full slot with `out_ready` low: `in_ready=0` for that `sel` only. Changing `sel` to an empty slot yields `in_ready=1` in the same cycle.
- All slots full and all ready low: unit stalls indefinitely without losing data.

## Structure
- Shared package `dmux_pkg`:
  - `DATA_W` default;
  - `SEL_W=2`;
  - `NUM_SLOTS=4`;
  - slot index constants `SLOT0`..`SLOT3`.
- Sub-module `dmux_slot_32`: one holding register with a load/drain/hold FSM (states EMPTY and FULL). It takes inputs `load`, `din`, `ready` and produces outputs `valid`, `dout`. The top level instantiates four of them plus the accept decode.

## Test plan
- Reset: assert `rst_n=0` for 2 cycles with `in_valid=1`, `sel=2`, `data_in=32'hDEADBEEF`. Required: `out_valid=4'b0000` and all `data_out=0`. After release, the first accept loads slot 2.
- Basic steer: write `32'h11111111`/sel0, `32'h22222222`/sel1, `32'h33333333`/sel2, `32'h44444444`/sel3 on consecutive cycles with `out_ready=0`. Required: `out_valid=4'b1111`, each `data_out_k` matches its word, and `busy=1`.
- Backpressure: slot 1 full and `out_ready[1]=0`, offer `sel=1`. Required: `in_ready=0`, and slot 1 still holds the old word after 5 cycles. Switching to `sel=3` (empty) gives `in_ready=1` in the same cycle.
- Streaming: `sel=0` and `out_ready[0]=1` continuously, 8 words `0..7`, one per cycle. Required: `in_ready` stays 1 and sink 0 receives 0..7 in order, one per cycle, each one cycle after acceptance.
- Simultaneous: slot 2 full with `A`, `out_ready[2]=1`, and new word `B` to `sel=2`, plus a drain of slot 0 in the same cycle. Required next cycle: `data_out_2=B`, `out_valid[2]=1`, `out_valid[0]=0`.
- Reset mid-traffic: all slots full, then a `rst_n` pulse. Required: all valid 0 and `in_ready=1` in the cycle after reset.
